dadder_dp_in_arb: RTL and testbench

DADDER_DP_IN_ARB -- requirements
Module: dadder_dp_in_arb

---
 rtl/dadder_dp_in_arb.sv | 120 ++++++++++++
 tb/tb_dadder_dp_in_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dadder_dp_in_arb.sv
// ---------------------------------------------------------------------------
// dadder_dp_in_arb
//
// Two-requester round-robin input arbiter for the decimal adder datapath.
// Requesters A and B each offer an operand pair with a valid/ready handshake.
// The winner is captured into a single output register slot that drives the
// datapath input (dp_*). The slot can be reloaded on the same edge it is
// consumed, so one pair per cycle flows when the datapath never stalls.
//
// Optional feature: define DADDER_DP_IN_ARB_STATS_EN to add per-requester
// saturating grant counters (a_grant_cnt, b_grant_cnt) with a synchronous
// clear (stat_clr). Without the macro those ports and counters are absent
// and the arbitration behaviour is unchanged.
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   reset_n             asynchronous active-low reset
//   a_valid/a_ready     requester A handshake (a_ready is combinational)
//   a_op_a/a_op_b       requester A operand pair
//   b_valid/b_ready     requester B handshake (b_ready is combinational)
//   b_op_a/b_op_b       requester B operand pair
//   dp_valid/dp_ready   datapath handshake (dp_valid is registered)
//   dp_op_a/dp_op_b     forwarded operand pair
//   dp_src              source of the presented pair (0 = A, 1 = B)
//   stat_clr            clear both grant counters      (stats build only)
//   a_grant_cnt         grants issued to A, saturating (stats build only)
//   b_grant_cnt         grants issued to B, saturating (stats build only)
// ---------------------------------------------------------------------------
module dadder_dp_in_arb #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_op_a,
    input  logic [DATA_W-1:0] a_op_b,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_op_a,
    input  logic [DATA_W-1:0] b_op_b,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic [DATA_W-1:0] dp_op_a,
    output logic [DATA_W-1:0] dp_op_b,
    output logic              dp_src
`ifdef DADDER_DP_IN_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  a_grant_cnt,
    output logic [CNT_W-1:0]  b_grant_cnt
`endif
);

    // Priority pointer: 0 = A preferred, 1 = B preferred.
    logic prio;

    logic load_ok;
    logic pick_b;
    logic grant_a;
    logic grant_b;

    // The slot can accept a new pair when empty or when it is being drained
    // on this very edge.
    assign load_ok = !dp_valid || dp_ready;

    // B wins when it is the only requester, or when both request and B holds
    // priority; otherwise A wins if it is requesting.
    assign pick_b  = b_valid && (!a_valid || prio);

    // reset_n gates the grants so neither ready is raised while reset is held.
    assign grant_a = reset_n && load_ok && a_valid && !pick_b;
    assign grant_b = reset_n && load_ok && pick_b;

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Output slot and priority pointer. dp_valid depends only on registered
    // state, so there is no combinational path from the request valids.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_valid <= 1'b0;
            dp_op_a  <= '0;
            dp_op_b  <= '0;
            dp_src   <= 1'b0;
            prio     <= 1'b0;
        end else if (grant_a || grant_b) begin
            dp_valid <= 1'b1;
            dp_op_a  <= grant_b ? b_op_a : a_op_a;
            dp_op_b  <= grant_b ? b_op_b : a_op_b;
            dp_src   <= grant_b;
            // Hand priority to whoever lost (or did not ask) this time.
            prio     <= grant_a;
        end else if (dp_ready) begin
            dp_valid <= 1'b0;
        end
    end

`ifdef DADDER_DP_IN_ARB_STATS_EN
    // Saturating grant counters; clear takes precedence over counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
        end else if (stat_clr) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
        end else begin
            if (grant_a && (a_grant_cnt != {CNT_W{1'b1}})) begin
                a_grant_cnt <= a_grant_cnt + 1'b1;
            end
            if (grant_b && (b_grant_cnt != {CNT_W{1'b1}})) begin
                b_grant_cnt <= b_grant_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dadder_dp_in_arb.sv
// ---------------------------------------------------------------------------
// Testbench for dadder_dp_in_arb. Directed scenarios followed by a random
// phase, all checked against a transaction-level model of the arbiter (one
// holding slot, a "who is preferred next" flag and saturating counters).
// Build with +define+DADDER_DP_IN_ARB_STATS_EN to also exercise the counters.
// ---------------------------------------------------------------------------
module tb_dadder_dp_in_arb;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              a_valid, b_valid, dp_ready;
    logic              a_ready, b_ready, dp_valid, dp_src;
    logic [DATA_W-1:0] a_op_a, a_op_b, b_op_a, b_op_b, dp_op_a, dp_op_b;
`ifdef DADDER_DP_IN_ARB_STATS_EN
    logic              stat_clr;
    logic [CNT_W-1:0]  a_grant_cnt, b_grant_cnt;
`endif

    dadder_dp_in_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_op_a(a_op_a), .a_op_b(a_op_b),
        .b_valid(b_valid), .b_ready(b_ready), .b_op_a(b_op_a), .b_op_b(b_op_b),
        .dp_valid(dp_valid), .dp_ready(dp_ready),
        .dp_op_a(dp_op_a), .dp_op_b(dp_op_b), .dp_src(dp_src)
`ifdef DADDER_DP_IN_ARB_STATS_EN
        , .stat_clr(stat_clr), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    bit                m_full;      // slot holds a pair
    bit [DATA_W-1:0]   m_a, m_b;    // held pair
    bit                m_src;       // held source
    bit                m_b_next;    // B is preferred at next contention
    int                m_cnt_a, m_cnt_b;
    int                last_winner; // -1 none, 0 A, 1 B

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_a = '0; m_b = '0; m_src = 0; m_b_next = 0;
        m_cnt_a = 0; m_cnt_b = 0; last_winner = -1;
    endtask

    // Inputs are already driven (edge+1). Check, advance the model, clock.
    task automatic cycle();
        int  winner;
        bit  room;
        #3;
        room = !m_full || dp_ready;
        winner = -1;
        if (room) begin
            if (a_valid && b_valid) winner = m_b_next ? 1 : 0;
            else if (a_valid)       winner = 0;
            else if (b_valid)       winner = 1;
        end
        check("a_ready", a_ready, winner == 0);
        check("b_ready", b_ready, winner == 1);
        check("dp_valid", dp_valid, m_full);
        if (m_full) begin
            check("dp_op_a", dp_op_a, m_a);
            check("dp_op_b", dp_op_b, m_b);
            check("dp_src", dp_src, m_src);
        end
`ifdef DADDER_DP_IN_ARB_STATS_EN
        check("a_grant_cnt", a_grant_cnt, m_cnt_a);
        check("b_grant_cnt", b_grant_cnt, m_cnt_b);
        if (stat_clr) begin
            m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            if (winner == 0 && m_cnt_a < CNT_MAX) m_cnt_a++;
            if (winner == 1 && m_cnt_b < CNT_MAX) m_cnt_b++;
        end
`endif
        if (winner == 0) begin
            m_full = 1; m_a = a_op_a; m_b = a_op_b; m_src = 0; m_b_next = 1;
        end else if (winner == 1) begin
            m_full = 1; m_a = b_op_a; m_b = b_op_b; m_src = 1; m_b_next = 0;
        end else if (dp_ready) begin
            m_full = 0;
        end
        last_winner = winner;
        $display("cycle t=%0t av=%0b bv=%0b dr=%0b grant=%0d dp_valid=%0b dp_src=%0b",
                 $time, a_valid, b_valid, dp_ready, winner, dp_valid, dp_src);
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ops();
        a_op_a = $urandom; a_op_b = $urandom;
        b_op_a = $urandom; b_op_b = $urandom;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check("rst_dp_valid", dp_valid, 1'b0);
        check("rst_dp_src", dp_src, 1'b0);
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        a_valid = 0; b_valid = 0; dp_ready = 0;
        a_op_a = '0; a_op_b = '0; b_op_a = '0; b_op_b = '0;
`ifdef DADDER_DP_IN_ARB_STATS_EN
        stat_clr = 0;
`endif
        reset_n = 1'b1;
        #3;
        do_reset();
        check("rst_dp_op_a", dp_op_a, 0);
        check("rst_dp_op_b", dp_op_b, 0);

        // Single A request with literal BCD operands.
        a_valid = 1; a_op_a = 32'h0000_0019; a_op_b = 32'h0000_0023; dp_ready = 1;
        cycle();
        a_valid = 0;
        check("single_a_op_a", dp_op_a, 32'h19);
        check("single_a_op_b", dp_op_b, 32'h23);
        check("single_a_src", dp_src, 1'b0);
        cycle();   // consumed, no grant -> slot drains
        check("drain_dp_valid", dp_valid, 1'b0);

        // Both valid from reset: alternating A,B,... with no idle cycle.
        do_reset();
        a_valid = 1; b_valid = 1; dp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            randomize_ops();
            cycle();
            check("alt_grant", last_winner, i % 2);
            check("alt_dp_valid", dp_valid, 1'b1);
            check("alt_dp_src", dp_src, i % 2);
        end

        // Stall: both valid, datapath not ready for 4 cycles.
        dp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            randomize_ops();
            cycle();
            check("stall_no_grant", last_winner, -1);
        end
        dp_ready = 1;
        randomize_ops();
        cycle();
        check("stall_resume_grant", last_winner, 0);

        // Reset while a pair is held and stalled: pair is discarded.
        dp_ready = 0;
        cycle();
        do_reset();
        a_valid = 1; b_valid = 1; dp_ready = 1;
        randomize_ops();
        cycle();
        check("post_rst_grant", last_winner, 0);

        // B alone with A preferred: B wins and A is preferred afterwards.
        do_reset();
        a_valid = 0; b_valid = 1;
        randomize_ops();
        cycle();
        check("b_alone_grant", last_winner, 1);
        a_valid = 1;
        randomize_ops();
        cycle();
        check("after_b_alone_grant", last_winner, 0);

`ifdef DADDER_DP_IN_ARB_STATS_EN
        // Saturation and clear with a 2-bit counter.
        do_reset();
        a_valid = 1; b_valid = 0; dp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            randomize_ops();
            cycle();
        end
        check("sat_a_cnt", a_grant_cnt, 2'd3);
        b_valid = 1; stat_clr = 1;
        cycle();
        stat_clr = 0;
        check("clr_a_cnt", a_grant_cnt, 2'd0);
        check("clr_b_cnt", b_grant_cnt, 2'd0);
`endif

        // Random phase.
        for (int i = 0; i < 400; i++) begin
            a_valid  = ($urandom_range(0, 9) < 6);
            b_valid  = ($urandom_range(0, 9) < 6);
            dp_ready = ($urandom_range(0, 9) < 7);
`ifdef DADDER_DP_IN_ARB_STATS_EN
            stat_clr = ($urandom_range(0, 31) == 0);
`endif
            randomize_ops();
            if (i == 200) begin
                do_reset();
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
